multicycle_control_fsm: RTL and testbench

Control state machine for the multicycle RISC-V core variant. It sequences a shared datapath (one memory port, one ALU, instruction/data registers) through fetch, decode and execute steps for lw, sw, R-type, I-type ALU, beq and jal. It replaces the single-cycle opcode decoder plus branch logic. ALU function selection remains in the separate ALU decoder, driven by `alu_op`.

---
 rtl/multicycle_control_fsm_if.sv | 34 +++
 rtl/multicycle_control_fsm.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the shared datapath.
//   master: FSM side. Takes op/zero/mem_ready and drives every control strobe and select.
//   slave : datapath side, with the directions reversed.
interface multicycle_control_fsm_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       illegal_instr;

  modport master (
    input  op, zero, mem_ready,
    output pc_write, adr_src, ir_write, mem_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_op,
           instr_done, illegal_instr
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_write, adr_src, ir_write, mem_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_op,
           instr_done, illegal_instr
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Control FSM for the multicycle RISC-V core. It steps one shared datapath
// through fetch, decode and execute for lw, sw, R-type, I-type ALU, beq and jal.
// Ports:
//   clk   - core clock, rising edge.
//   reset - synchronous, active-high. Returns the FSM to FETCH.
//   bus   - master modport. Carries op/zero/mem_ready in and all control outputs out.
module multicycle_control_fsm (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Per-state Moore outputs. ready_gate marks states whose strobes wait on mem_ready.
  typedef struct packed {
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       pc_update;
    logic       branch;
    logic       instr_done;
    logic       ready_gate;
    logic       illegal;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctl_t;

  function automatic ctl_t decode_ctl(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.ir_write   = 1'b1;
        c.pc_update  = 1'b1;
        c.ready_gate = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = 1'b1;
        c.ready_gate = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = 2'b10;
        c.alu_op     = 2'b01;
        c.branch     = 1'b1;
        c.instr_done = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      S_TRAP:  c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  state_t state_q, state_d;
  ctl_t   ctl_q, ctl_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    // Decode from the next state so the Moore outputs come straight from flops.
    ctl_d = decode_ctl(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctl_q   <= decode_ctl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  // Only mem_ready, zero and reset act combinationally on the registered state outputs.
  logic ready_ok;
  logic pc_update;
  assign ready_ok  = bus.mem_ready | ~ctl_q.ready_gate;
  assign pc_update = ctl_q.pc_update & ready_ok;

  assign bus.pc_write      = ~reset & (pc_update | (ctl_q.branch & bus.zero));
  assign bus.ir_write      = ~reset & ctl_q.ir_write & ready_ok;
  assign bus.mem_write     = ~reset & ctl_q.mem_write;
  assign bus.reg_write     = ~reset & ctl_q.reg_write;
  assign bus.instr_done    = ctl_q.instr_done & ready_ok;
  assign bus.adr_src       = ctl_q.adr_src;
  assign bus.alu_src_a     = ctl_q.alu_src_a;
  assign bus.alu_src_b     = ctl_q.alu_src_b;
  assign bus.result_src    = ctl_q.result_src;
  assign bus.alu_op        = ctl_q.alu_op;
  assign bus.illegal_instr = ctl_q.illegal;

  always_comb begin
    case (bus.op)
      OP_SW:   bus.imm_src = 2'b01;
      OP_BEQ:  bus.imm_src = 2'b10;
      OP_JAL:  bus.imm_src = 2'b11;
      default: bus.imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. All control outputs except imm_src
// are packed into obs as {pc_write, adr_src, ir_write, mem_write, reg_write,
// alu_src_a, alu_src_b, result_src, alu_op, instr_done, illegal_instr}.
// Each cycle, obs is compared with a hand-written vector for the expected state.
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [14:0] obs;
  assign obs = {bus.pc_write, bus.adr_src, bus.ir_write, bus.mem_write, bus.reg_write,
                bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_op,
                bus.instr_done, bus.illegal_instr};

  //                                  p a i m r AA BB RR OO d t
  localparam logic [14:0] E_FRDY    = 15'b1_0_1_0_0_00_10_10_00_0_0;
  localparam logic [14:0] E_FSTALL  = 15'b0_0_0_0_0_00_10_10_00_0_0;
  localparam logic [14:0] E_DECODE  = 15'b0_0_0_0_0_01_01_00_00_0_0;
  localparam logic [14:0] E_MEMADR  = 15'b0_0_0_0_0_10_01_00_00_0_0;
  localparam logic [14:0] E_MEMREAD = 15'b0_1_0_0_0_00_00_00_00_0_0;
  localparam logic [14:0] E_MEMWB   = 15'b0_0_0_0_1_00_00_01_00_1_0;
  localparam logic [14:0] E_MWRDY   = 15'b0_1_0_1_0_00_00_00_00_1_0;
  localparam logic [14:0] E_MWSTALL = 15'b0_1_0_1_0_00_00_00_00_0_0;
  localparam logic [14:0] E_EXECR   = 15'b0_0_0_0_0_10_00_00_10_0_0;
  localparam logic [14:0] E_EXECI   = 15'b0_0_0_0_0_10_01_00_10_0_0;
  localparam logic [14:0] E_ALUWB   = 15'b0_0_0_0_1_00_00_00_00_1_0;
  localparam logic [14:0] E_BEQ_Z1  = 15'b1_0_0_0_0_10_00_00_01_1_0;
  localparam logic [14:0] E_BEQ_Z0  = 15'b0_0_0_0_0_10_00_00_01_1_0;
  localparam logic [14:0] E_JAL     = 15'b1_0_0_0_0_01_10_00_00_0_0;
  localparam logic [14:0] E_TRAP    = 15'b0_0_0_0_0_00_00_00_00_0_1;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.mem_ready = 1'b1; bus.zero = 1'b0; bus.op = OP_LW;
    tick(); #2;
    checks++; if (obs !== E_FSTALL) begin errors++; $display("FAIL reset_hold obs=%b exp=%b", obs, E_FSTALL); end
    reset = 1'b0; #1;
    checks++; if (obs !== E_FRDY) begin errors++; $display("FAIL reset_fetch obs=%b exp=%b", obs, E_FRDY); end
    tick(); tick(); tick(); bus.mem_ready = 1'b0; #2;
    checks++; if (obs !== E_MEMREAD) begin errors++; $display("FAIL reset_pre_memread obs=%b exp=%b", obs, E_MEMREAD); end
    reset = 1'b1;
    tick(); #2;
    checks++; if (obs !== E_FSTALL) begin errors++; $display("FAIL reset_mid_access obs=%b exp=%b", obs, E_FSTALL); end
    reset = 1'b0; bus.mem_ready = 1'b1; #1;
    checks++; if (obs !== E_FRDY) begin errors++; $display("FAIL reset_release_fetch obs=%b exp=%b", obs, E_FRDY); end
  endtask

  task automatic test_lw();
    bus.op = OP_LW; bus.mem_ready = 1'b1; #1;
    checks++; if (obs !== E_FRDY) begin errors++; $display("FAIL lw_c1_fetch obs=%b exp=%b", obs, E_FRDY); end
    tick(); #2;
    checks++; if (obs !== E_DECODE) begin errors++; $display("FAIL lw_c2_decode obs=%b exp=%b", obs, E_DECODE); end
    checks++; if (bus.imm_src !== 2'b00) begin errors++; $display("FAIL lw_imm_src got=%b exp=00", bus.imm_src); end
    tick(); #2;
    checks++; if (obs !== E_MEMADR) begin errors++; $display("FAIL lw_c3_memadr obs=%b exp=%b", obs, E_MEMADR); end
    tick(); #2;
    checks++; if (obs !== E_MEMREAD) begin errors++; $display("FAIL lw_c4_memread obs=%b exp=%b", obs, E_MEMREAD); end
    tick(); #2;
    checks++; if (obs !== E_MEMWB) begin errors++; $display("FAIL lw_c5_memwb obs=%b exp=%b", obs, E_MEMWB); end
    tick(); #2;
    checks++; if (obs !== E_FRDY) begin errors++; $display("FAIL lw_back_fetch obs=%b exp=%b", obs, E_FRDY); end
  endtask

  task automatic test_sw_stall();
    bus.op = OP_SW; bus.mem_ready = 1'b1; #1;
    checks++; if (bus.imm_src !== 2'b01) begin errors++; $display("FAIL sw_imm_src got=%b exp=01", bus.imm_src); end
    tick(); #2;
    checks++; if (obs !== E_DECODE) begin errors++; $display("FAIL sw_decode obs=%b exp=%b", obs, E_DECODE); end
    tick(); #2;
    checks++; if (obs !== E_MEMADR) begin errors++; $display("FAIL sw_memadr obs=%b exp=%b", obs, E_MEMADR); end
    tick(); bus.mem_ready = 1'b0; #2;
    checks++; if (obs !== E_MWSTALL) begin errors++; $display("FAIL sw_memwrite_stall1 obs=%b exp=%b", obs, E_MWSTALL); end
    tick(); #2;
    checks++; if (obs !== E_MWSTALL) begin errors++; $display("FAIL sw_memwrite_stall2 obs=%b exp=%b", obs, E_MWSTALL); end
    tick(); bus.mem_ready = 1'b1; #2;
    checks++; if (obs !== E_MWRDY) begin errors++; $display("FAIL sw_memwrite_done obs=%b exp=%b", obs, E_MWRDY); end
    tick(); #2;
    checks++; if (obs !== E_FRDY) begin errors++; $display("FAIL sw_back_fetch obs=%b exp=%b", obs, E_FRDY); end
  endtask

  task automatic test_alu_ops();
    bus.op = OP_R; #1;
    tick(); #2;
    checks++; if (obs !== E_DECODE) begin errors++; $display("FAIL rtype_decode obs=%b exp=%b", obs, E_DECODE); end
    tick(); #2;
    checks++; if (obs !== E_EXECR) begin errors++; $display("FAIL rtype_execute obs=%b exp=%b", obs, E_EXECR); end
    tick(); #2;
    checks++; if (obs !== E_ALUWB) begin errors++; $display("FAIL rtype_aluwb obs=%b exp=%b", obs, E_ALUWB); end
    tick(); bus.op = OP_I; #2;
    checks++; if (obs !== E_FRDY) begin errors++; $display("FAIL rtype_back_fetch obs=%b exp=%b", obs, E_FRDY); end
    tick(); tick(); #2;
    checks++; if (obs !== E_EXECI) begin errors++; $display("FAIL itype_execute obs=%b exp=%b", obs, E_EXECI); end
    tick(); #2;
    checks++; if (obs !== E_ALUWB) begin errors++; $display("FAIL itype_aluwb obs=%b exp=%b", obs, E_ALUWB); end
    tick(); #2;
    checks++; if (obs !== E_FRDY) begin errors++; $display("FAIL itype_back_fetch obs=%b exp=%b", obs, E_FRDY); end
  endtask

  task automatic test_beq();
    bus.op = OP_BEQ; bus.zero = 1'b1; #1;
    checks++; if (bus.imm_src !== 2'b10) begin errors++; $display("FAIL beq_imm_src got=%b exp=10", bus.imm_src); end
    tick(); tick(); #2;
    checks++; if (obs !== E_BEQ_Z1) begin errors++; $display("FAIL beq_taken obs=%b exp=%b", obs, E_BEQ_Z1); end
    bus.zero = 1'b0; #1;
    checks++; if (obs !== E_BEQ_Z0) begin errors++; $display("FAIL beq_zero_follow obs=%b exp=%b", obs, E_BEQ_Z0); end
    bus.zero = 1'b1;
    tick(); #2;
    checks++; if (obs !== E_FRDY) begin errors++; $display("FAIL beq_taken_back_fetch obs=%b exp=%b", obs, E_FRDY); end
    bus.zero = 1'b0;
    tick(); #2;
    checks++; if (obs !== E_DECODE) begin errors++; $display("FAIL beq_nt_decode obs=%b exp=%b", obs, E_DECODE); end
    tick(); #2;
    checks++; if (obs !== E_BEQ_Z0) begin errors++; $display("FAIL beq_not_taken obs=%b exp=%b", obs, E_BEQ_Z0); end
    tick(); #2;
    checks++; if (obs !== E_FRDY) begin errors++; $display("FAIL beq_nt_back_fetch obs=%b exp=%b", obs, E_FRDY); end
  endtask

  task automatic test_jal_stall();
    bus.op = OP_JAL; bus.mem_ready = 1'b0; #1;
    checks++; if (obs !== E_FSTALL) begin errors++; $display("FAIL jal_fetch_stall1 obs=%b exp=%b", obs, E_FSTALL); end
    checks++; if (bus.imm_src !== 2'b11) begin errors++; $display("FAIL jal_imm_src got=%b exp=11", bus.imm_src); end
    tick(); #2;
    checks++; if (obs !== E_FSTALL) begin errors++; $display("FAIL jal_fetch_stall2 obs=%b exp=%b", obs, E_FSTALL); end
    tick(); #2;
    checks++; if (obs !== E_FSTALL) begin errors++; $display("FAIL jal_fetch_stall3 obs=%b exp=%b", obs, E_FSTALL); end
    tick(); bus.mem_ready = 1'b1; #2;
    checks++; if (obs !== E_FRDY) begin errors++; $display("FAIL jal_fetch_go obs=%b exp=%b", obs, E_FRDY); end
    tick(); #2;
    checks++; if (obs !== E_DECODE) begin errors++; $display("FAIL jal_decode obs=%b exp=%b", obs, E_DECODE); end
    tick(); #2;
    checks++; if (obs !== E_JAL) begin errors++; $display("FAIL jal_jal obs=%b exp=%b", obs, E_JAL); end
    tick(); #2;
    checks++; if (obs !== E_ALUWB) begin errors++; $display("FAIL jal_aluwb obs=%b exp=%b", obs, E_ALUWB); end
    tick(); #2;
    checks++; if (obs !== E_FRDY) begin errors++; $display("FAIL jal_back_fetch obs=%b exp=%b", obs, E_FRDY); end
  endtask

  task automatic test_illegal();
    bus.op = OP_BAD; #1;
    tick(); #2;
    checks++; if (obs !== E_DECODE) begin errors++; $display("FAIL bad_decode obs=%b exp=%b", obs, E_DECODE); end
    checks++; if (bus.imm_src !== 2'b00) begin errors++; $display("FAIL bad_imm_src got=%b exp=00", bus.imm_src); end
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = i[0];
      bus.zero      = ~i[0];
      #2;
      checks++; if (obs !== E_TRAP) begin errors++; $display("FAIL trap_hold_%0d obs=%b exp=%b", i, obs, E_TRAP); end
      tick();
    end
    reset = 1'b1; bus.mem_ready = 1'b1; bus.zero = 1'b0; #2;
    checks++; if (obs !== E_TRAP) begin errors++; $display("FAIL trap_under_reset obs=%b exp=%b", obs, E_TRAP); end
    tick(); reset = 1'b0; #2;
    checks++; if (obs !== E_FRDY) begin errors++; $display("FAIL trap_reset_fetch obs=%b exp=%b", obs, E_FRDY); end
    bus.op = OP_LW;
    tick(); #2;
    checks++; if (obs !== E_DECODE) begin errors++; $display("FAIL post_trap_decode obs=%b exp=%b", obs, E_DECODE); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_alu_ops();
    test_beq();
    test_jal_stall();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
